ext_di_conditioner: RTL and testbench
=====================================

Name: ext_di_conditioner

Overview:
- Conditions the raw external digital inputs before the operation FSM uses them as o_ext_di: bit3 phase/discharge, bit2 slow-charge relay, bit1 main contactor, bit0 spare.
- Per channel: 2-FF synchroniser, then a debounce filter.
- Also produces edge pulses and per-channel glitch counters.
- Also produces a latched first-fault interlock that drives the FSM interlock input.

Parameters:
- CH, 4, number of digital input channels.
- DEBOUNCE_CYC, 2000, consecutive stable cycles needed to accept a new level (10 us at 200 MHz); legal range 2..65535.
- INIT_VAL, 4'b0000, o_ext_di value on reset.
- GCNT_W, 8, width of each glitch counter.

Ports:
- i_clk, in, 1, system clock (200 MHz).
- i_rst, in, 1, synchronous active-high reset.
- i_ext_di_raw, in, CH, asynchronous raw field inputs.
- i_intl_mask, in, CH, 1 = channel at level 1 raises the interlock.
- i_intl_clr, in, 1, single-cycle pulse requesting interlock clear.
- i_cnt_clr, in, 1, single-cycle pulse clearing all glitch counters.
- o_ext_di, out, CH, debounced levels, to the operation FSM.
- o_di_rise, out, CH, one-cycle pulse when a channel's o_ext_di goes 0->1.
- o_di_fall, out, CH, one-cycle pulse when a channel's o_ext_di goes 1->0.
- o_glitch_cnt, out, CH*GCNT_W, packed saturating glitch counters; channel n occupies bits [n*GCNT_W +: GCNT_W].
- o_intl, out, 1, latched interlock.
- o_intl_src, out, CH, channel(s) that caused the first interlock.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - sync FFs, o_ext_di <= INIT_VAL.
  - Debounce counters, o_di_rise, o_di_fall, o_glitch_cnt, o_intl, o_intl_src <= 0.
  - Reset mid-debounce discards partial counts.
- Synchroniser: sync1 <= raw, sync2 <= sync1, per bit.
- Debounce, per channel, counter width 16:
  - If sync2 == o_ext_di[n]: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYC-1: o_ext_di[n] <= sync2, cnt <= 0, and the matching rise or fall pulse is asserted in that same cycle.
  - Else: cnt <= cnt+1.
- Latency: a raw change held stable appears on o_ext_di exactly DEBOUNCE_CYC+2 clock edges after the first edge that samples it.
- Pulses: o_di_rise/o_di_fall are high exactly one cycle, aligned with the o_ext_di change.
- Glitch: sync2 returning to o_ext_di[n] while cnt != 0 increments glitch_cnt[n].
  - Saturates at all-ones; no wrap.
  - i_cnt_clr zeroes all counters; if clear and increment coincide, clear wins.
- Interlock state machine, two states:
  - IDLE: o_intl=0. If (o_ext_di & i_intl_mask) != 0 -> TRIP, o_intl <= 1, o_intl_src <= (o_ext_di & i_intl_mask), capturing all channels active that cycle.
  - TRIP: o_intl=1 and o_intl_src is frozen; later faults do not update it.
  - TRIP -> IDLE only when i_intl_clr=1 and (o_ext_di & i_intl_mask)==0 in the same cycle. On that transition o_intl <= 0 and o_intl_src <= 0.
  - i_intl_clr while the condition is still present is ignored: no state change, and the pulse is not remembered.
  - i_intl_clr while in IDLE has no effect.
- Mask changes take effect the next cycle. Unmasking a channel does not clear TRIP.
- All outputs are registered; no combinational paths from inputs to outputs.

Test Plan (bench uses DEBOUNCE_CYC=4, CH=4, INIT_VAL=0):
- Reset then release; raw=4'b0100 held -> o_ext_di=4'b0100 and o_di_rise[2]=1 for one cycle, exactly 6 edges after the first sampling edge. o_di_fall stays 0.
- raw[1] pulses high for 3 cycles, then low -> o_ext_di[1] stays 0 and glitch_cnt[1]=1. Repeat 300 times -> glitch_cnt[1] saturates at 255. Pulse i_cnt_clr -> 0.
- i_intl_mask=4'b1000; raw[3] goes high -> o_intl=1 and o_intl_src=4'b1000. Pulse i_intl_clr while raw[3]=1 -> still 1. Drop raw[3], wait 6 cycles, pulse clr -> o_intl=0, o_intl_src=0.
- Mask=4'b1010; raw[1] and raw[3] rise together -> o_intl_src=4'b1010. A later raw[0] fault with mask bit0 set -> o_intl_src is unchanged.
- Assert i_rst with 2 of 4 debounce cycles elapsed on raw[2] -> o_ext_di=0 and the counter restarts; the accepted edge occurs 6 edges after reset release.
- Run the on/off sequence (ext_di[2] rise, ext_di[1] rise, ext_di[2] fall) -> rise/fall pulses appear in order, each exactly one cycle.

Source files
------------

// File: rtl/ext_di_conditioner_if.sv
// Bundle of the external digital-input conditioner signals.
// master drives the raw inputs and controls; slave is the conditioner.
interface ext_di_conditioner_if #(
    parameter int CH     = 4,
    parameter int GCNT_W = 8
);
    logic [CH-1:0]        i_ext_di_raw;
    logic [CH-1:0]        i_intl_mask;
    logic                 i_intl_clr;
    logic                 i_cnt_clr;
    logic [CH-1:0]        o_ext_di;
    logic [CH-1:0]        o_di_rise;
    logic [CH-1:0]        o_di_fall;
    logic [CH*GCNT_W-1:0] o_glitch_cnt;
    logic                 o_intl;
    logic [CH-1:0]        o_intl_src;

    modport master (
        output i_ext_di_raw, i_intl_mask, i_intl_clr, i_cnt_clr,
        input  o_ext_di, o_di_rise, o_di_fall, o_glitch_cnt,
        input  o_intl, o_intl_src
    );

    modport slave (
        input  i_ext_di_raw, i_intl_mask, i_intl_clr, i_cnt_clr,
        output o_ext_di, o_di_rise, o_di_fall, o_glitch_cnt,
        output o_intl, o_intl_src
    );
endinterface

// File: rtl/ext_di_conditioner.sv
// External DI conditioner: sync, debounce, edges, glitch counts,
// and a latched first-fault interlock for the operation FSM.
module ext_di_conditioner #(
    parameter int            CH           = 4,
    parameter int            DEBOUNCE_CYC = 2000,
    parameter logic [CH-1:0] INIT_VAL     = '0,
    parameter int            GCNT_W       = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    ext_di_conditioner_if.slave  bus
);
    localparam logic [15:0] LAST = 16'(DEBOUNCE_CYC - 1);

    typedef enum logic {IDLE, TRIP} state_t;

    logic [CH-1:0]             sync1;
    logic [CH-1:0]             sync2;
    logic [CH-1:0]             ext_di;
    logic [CH-1:0]             rise;
    logic [CH-1:0]             fall;
    logic [CH-1:0][15:0]       cnt;
    logic [CH-1:0][GCNT_W-1:0] gcnt;
    logic [CH-1:0]             hit;
    logic [CH-1:0]             src;
    logic [CH-1:0]             src_nxt;
    state_t                    state;
    state_t                    state_nxt;

    // Two-flop synchroniser on every raw field input.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1 <= INIT_VAL;
            sync2 <= INIT_VAL;
        end else begin
            sync1 <= bus.i_ext_di_raw;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYC stable cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ext_di <= INIT_VAL;
            rise   <= '0;
            fall   <= '0;
            cnt    <= '0;
        end else begin
            rise <= '0;
            fall <= '0;
            for (int n = 0; n < CH; n++) begin
                if (sync2[n] == ext_di[n]) begin
                    cnt[n] <= '0;
                end else if (cnt[n] == LAST) begin
                    ext_di[n] <= sync2[n];
                    cnt[n]    <= '0;
                    rise[n]   <= sync2[n];
                    fall[n]   <= ~sync2[n];
                end else begin
                    cnt[n] <= cnt[n] + 16'd1;
                end
            end
        end
    end

    // Count aborted debounce windows; saturate, clear has priority.
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_cnt_clr) begin
            gcnt <= '0;
        end else begin
            for (int n = 0; n < CH; n++) begin
                if (sync2[n] == ext_di[n] && cnt[n] != '0
                    && gcnt[n] != '1) begin
                    gcnt[n] <= gcnt[n] + 1'b1;
                end
            end
        end
    end

    assign hit = ext_di & bus.i_intl_mask;

    // Interlock state and first-fault source register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            src   <= '0;
        end else begin
            state <= state_nxt;
            src   <= src_nxt;
        end
    end

    // Trip on any masked active channel; clear only once it is gone.
    always_comb begin
        state_nxt = state;
        src_nxt   = src;
        unique case (state)
            IDLE: begin
                if (|hit) begin
                    state_nxt = TRIP;
                    src_nxt   = hit;
                end
            end
            TRIP: begin
                if (bus.i_intl_clr && !(|hit)) begin
                    state_nxt = IDLE;
                    src_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                src_nxt   = '0;
            end
        endcase
    end

    assign bus.o_ext_di     = ext_di;
    assign bus.o_di_rise    = rise;
    assign bus.o_di_fall    = fall;
    assign bus.o_glitch_cnt = gcnt;
    assign bus.o_intl       = (state == TRIP);
    assign bus.o_intl_src   = src;
endmodule

// File: tb/tb_ext_di_conditioner.sv
// Directed bench for ext_di_conditioner with DEBOUNCE_CYC=4:
// a vector table for edges/interlock plus glitch and reset sequences.
module tb_ext_di_conditioner;
    localparam int CH = 4;
    localparam int GW = 8;
    localparam int DC = 4;

    typedef struct {
        logic [3:0] raw;
        logic [3:0] mask;
        logic       iclr;
        int         ncyc;
        logic [3:0] ext;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       intl;
        logic [3:0] src;
    } vec_t;

    logic i_clk = 1'b0;
    logic i_rst;
    int   nvec = 0;
    int   nerr = 0;
    vec_t tbl [25];

    ext_di_conditioner_if #(.CH(CH), .GCNT_W(GW)) bus ();

    ext_di_conditioner #(
        .CH(CH),
        .DEBOUNCE_CYC(DC),
        .INIT_VAL(4'b0000),
        .GCNT_W(GW)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus(bus.slave)
    );

    always #5 i_clk = ~i_clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        step(2);
        i_rst = 1'b0;
    endtask

    task automatic glitch_pulse();
        bus.i_ext_di_raw = 4'b0010;
        step(3);
        bus.i_ext_di_raw = 4'b0000;
        step(5);
    endtask

    initial begin
        //        raw      mask     clr  n  ext      rise     fall     intl src
        tbl[0]  = '{4'b0100, 4'b0000, 1'b0, 5, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000};
        tbl[1]  = '{4'b0100, 4'b0000, 1'b0, 1, 4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0000};
        tbl[2]  = '{4'b0110, 4'b0000, 1'b0, 1, 4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000};
        tbl[3]  = '{4'b0110, 4'b0000, 1'b0, 4, 4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000};
        tbl[4]  = '{4'b0110, 4'b0000, 1'b0, 1, 4'b0110, 4'b0010, 4'b0000, 1'b0, 4'b0000};
        tbl[5]  = '{4'b0010, 4'b0000, 1'b0, 5, 4'b0110, 4'b0000, 4'b0000, 1'b0, 4'b0000};
        tbl[6]  = '{4'b0010, 4'b0000, 1'b0, 1, 4'b0010, 4'b0000, 4'b0100, 1'b0, 4'b0000};
        tbl[7]  = '{4'b0010, 4'b0000, 1'b0, 1, 4'b0010, 4'b0000, 4'b0000, 1'b0, 4'b0000};
        tbl[8]  = '{4'b1010, 4'b1000, 1'b0, 5, 4'b0010, 4'b0000, 4'b0000, 1'b0, 4'b0000};
        tbl[9]  = '{4'b1010, 4'b1000, 1'b0, 1, 4'b1010, 4'b1000, 4'b0000, 1'b0, 4'b0000};
        tbl[10] = '{4'b1010, 4'b1000, 1'b0, 1, 4'b1010, 4'b0000, 4'b0000, 1'b1, 4'b1000};
        tbl[11] = '{4'b1010, 4'b1000, 1'b1, 1, 4'b1010, 4'b0000, 4'b0000, 1'b1, 4'b1000};
        tbl[12] = '{4'b1010, 4'b1000, 1'b0, 1, 4'b1010, 4'b0000, 4'b0000, 1'b1, 4'b1000};
        tbl[13] = '{4'b0010, 4'b1000, 1'b0, 5, 4'b1010, 4'b0000, 4'b0000, 1'b1, 4'b1000};
        tbl[14] = '{4'b0010, 4'b1000, 1'b0, 1, 4'b0010, 4'b0000, 4'b1000, 1'b1, 4'b1000};
        tbl[15] = '{4'b0010, 4'b1000, 1'b1, 1, 4'b0010, 4'b0000, 4'b0000, 1'b0, 4'b0000};
        tbl[16] = '{4'b0010, 4'b1000, 1'b1, 1, 4'b0010, 4'b0000, 4'b0000, 1'b0, 4'b0000};
        tbl[17] = '{4'b0000, 4'b0000, 1'b0, 6, 4'b0000, 4'b0000, 4'b0010, 1'b0, 4'b0000};
        tbl[18] = '{4'b1010, 4'b1010, 1'b0, 5, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000};
        tbl[19] = '{4'b1010, 4'b1010, 1'b0, 1, 4'b1010, 4'b1010, 4'b0000, 1'b0, 4'b0000};
        tbl[20] = '{4'b1010, 4'b1010, 1'b0, 1, 4'b1010, 4'b0000, 4'b0000, 1'b1, 4'b1010};
        tbl[21] = '{4'b1011, 4'b1011, 1'b0, 6, 4'b1011, 4'b0001, 4'b0000, 1'b1, 4'b1010};
        tbl[22] = '{4'b1011, 4'b1011, 1'b0, 1, 4'b1011, 4'b0000, 4'b0000, 1'b1, 4'b1010};
        tbl[23] = '{4'b1011, 4'b0000, 1'b0, 1, 4'b1011, 4'b0000, 4'b0000, 1'b1, 4'b1010};
        tbl[24] = '{4'b1011, 4'b0000, 1'b1, 1, 4'b1011, 4'b0000, 4'b0000, 1'b0, 4'b0000};

        bus.i_ext_di_raw = '0;
        bus.i_intl_mask  = '0;
        bus.i_intl_clr   = 1'b0;
        bus.i_cnt_clr    = 1'b0;
        do_reset();

        check("rst_ext", 32'(bus.o_ext_di), 32'h0);
        check("rst_rise", 32'(bus.o_di_rise), 32'h0);
        check("rst_fall", 32'(bus.o_di_fall), 32'h0);
        check("rst_gcnt", bus.o_glitch_cnt, 32'h0);
        check("rst_intl", 32'(bus.o_intl), 32'h0);
        check("rst_src", 32'(bus.o_intl_src), 32'h0);

        for (int k = 0; k < 25; k++) begin
            bus.i_ext_di_raw = tbl[k].raw;
            bus.i_intl_mask  = tbl[k].mask;
            bus.i_intl_clr   = tbl[k].iclr;
            step(tbl[k].ncyc);
            check($sformatf("v%0d_ext", k), 32'(bus.o_ext_di), 32'(tbl[k].ext));
            check($sformatf("v%0d_rise", k), 32'(bus.o_di_rise), 32'(tbl[k].rise));
            check($sformatf("v%0d_fall", k), 32'(bus.o_di_fall), 32'(tbl[k].fall));
            check($sformatf("v%0d_intl", k), 32'(bus.o_intl), 32'(tbl[k].intl));
            check($sformatf("v%0d_src", k), 32'(bus.o_intl_src), 32'(tbl[k].src));
        end
        bus.i_intl_clr  = 1'b0;
        bus.i_intl_mask = '0;
        check("tbl_gcnt", bus.o_glitch_cnt, 32'h0);

        bus.i_ext_di_raw = '0;
        do_reset();
        glitch_pulse();
        check("glitch_ext", 32'(bus.o_ext_di), 32'h0);
        check("glitch_one", bus.o_glitch_cnt, 32'h0000_0100);
        for (int i = 1; i < 300; i++) glitch_pulse();
        check("glitch_sat", bus.o_glitch_cnt, 32'h0000_ff00);
        check("glitch_sat_ext", 32'(bus.o_ext_di), 32'h0);
        bus.i_cnt_clr = 1'b1;
        step(1);
        bus.i_cnt_clr = 1'b0;
        check("cnt_clr", bus.o_glitch_cnt, 32'h0);

        bus.i_ext_di_raw = 4'b0010;
        step(3);
        bus.i_ext_di_raw = 4'b0000;
        step(2);
        bus.i_cnt_clr = 1'b1;
        step(1);
        bus.i_cnt_clr = 1'b0;
        check("clr_wins", bus.o_glitch_cnt, 32'h0);
        step(3);
        check("clr_wins_hold", bus.o_glitch_cnt, 32'h0);

        bus.i_ext_di_raw = 4'b0100;
        step(4);
        check("mid_ext", 32'(bus.o_ext_di), 32'h0);
        i_rst = 1'b1;
        step(1);
        i_rst = 1'b0;
        check("mid_rst_ext", 32'(bus.o_ext_di), 32'h0);
        step(5);
        check("post_rst_5", 32'(bus.o_ext_di), 32'h0);
        step(1);
        check("post_rst_6", 32'(bus.o_ext_di), 32'h4);
        check("post_rst_rise", 32'(bus.o_di_rise), 32'h4);
        step(1);
        check("post_rst_rise_off", 32'(bus.o_di_rise), 32'h0);
        check("post_rst_gcnt", bus.o_glitch_cnt, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
